// File: rtl/fxp_arith_pkg.sv
// Shared fixed-point helpers for the sequential divider/multiplier pair: width defaults,
// the FSM state type, and the sign/magnitude codec that keeps both blocks' formats identical.
package fxp_arith_pkg;

  localparam int QW_DEF  = 32;
  localparam int FW_DEF  = 16;
  localparam int MW_DEF  = 32;
  localparam int SM_MAXW = 128;

  typedef logic [SM_MAXW-1:0] sm_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fxp_state_e;

  typedef struct packed {
    logic     sign;
    sm_word_t mag;
  } sm_dec_t;

  typedef struct packed {
    sm_word_t int_v;
    sm_word_t frac;
  } sm_enc_t;

  function automatic sm_word_t low_mask(input int w);
    return (sm_word_t'(1) << w) - sm_word_t'(1);
  endfunction

  // {sign, two's-complement magnitude} integer plus fraction magnitude -> {sign, unsigned magnitude}
  function automatic sm_dec_t sm_decode(input sm_word_t int_v, input sm_word_t frac,
                                        input int iw, input int fw);
    sm_dec_t  d;
    sm_word_t low;
    low    = int_v & low_mask(iw - 1);
    d.sign = |(int_v & (sm_word_t'(1) << (iw - 1)));
    if (d.sign) low = (~low + sm_word_t'(1)) & low_mask(iw - 1);
    d.mag  = (low << fw) | (frac & low_mask(fw));
    return d;
  endfunction

  // Inverse of sm_decode; a zero magnitude always encodes with a clear sign bit.
  function automatic sm_enc_t sm_encode(input logic sign, input sm_word_t mag,
                                        input int iw, input int fw);
    sm_enc_t  e;
    sm_word_t top;
    logic     s;
    s   = sign & (mag != '0);
    top = (mag >> fw) & low_mask(iw - 1);
    if (s) top = (~top + sm_word_t'(1)) & low_mask(iw - 1);
    e.int_v = top | (sm_word_t'(s) << (iw - 1));
    e.frac  = mag & low_mask(fw);
    return e;
  endfunction

endpackage

// File: rtl/fxp_multiplier_seq_if.sv
// Request/response bundle of the sequential fixed-point multiplier.
interface fxp_multiplier_seq_if
  import fxp_arith_pkg::*;
#(
  parameter int QW = QW_DEF,
  parameter int FW = FW_DEF,
  parameter int MW = MW_DEF
) ();

  // Handshake: start is taken on an edge where busy is low, with operands sampled on that
  // same edge; busy stays high until done, and done is a one-cycle pulse after which
  // product_int/product_frac are valid and held until the next done or reset.
  logic            start;
  logic [QW-1:0]   quotient;
  logic [FW-1:0]   fractional;
  logic [MW-1:0]   multiplier;
  logic            busy;
  logic            done;
  logic [QW+MW-1:0] product_int;
  logic [FW-1:0]   product_frac;
  fxp_state_e      dbg_state;

  modport master (
    output start, quotient, fractional, multiplier,
    input  busy, done, product_int, product_frac, dbg_state
  );

  modport slave (
    input  start, quotient, fractional, multiplier,
    output busy, done, product_int, product_frac, dbg_state
  );

endinterface

// File: rtl/fxp_multiplier_seq.sv
// Shift-add multiplier of a sign/magnitude fixed-point operand by a signed integer,
// one multiplier bit per clock; done is the (MW+1)th cycle after start is presented.
module fxp_multiplier_seq
  import fxp_arith_pkg::*;
#(
  parameter int QUOTIENT_WIDTH   = QW_DEF,
  parameter int FRACTIONAL_WIDTH = FW_DEF,
  parameter int MULT_WIDTH       = MW_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  fxp_multiplier_seq_if.slave mul_if
);

  localparam int QW   = QUOTIENT_WIDTH;
  localparam int FW   = FRACTIONAL_WIDTH;
  localparam int MW   = MULT_WIDTH;
  localparam int AW   = QW - 1 + FW;
  localparam int ACCW = AW + MW;
  localparam int PW   = QW + MW;
  localparam int CW   = $clog2(MW + 1);
  localparam logic [CW-1:0] LAST = CW'(MW - 1);

  fxp_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   mag_a_q, mag_a_d;
  logic [MW-1:0]   mag_m_q, mag_m_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic            sign_q, sign_d;
  logic [PW-1:0]   pint_q, pint_d;
  logic [FW-1:0]   pfrac_q, pfrac_d;
  sm_dec_t         dec;
  sm_enc_t         enc;
  logic            unused_bits;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_a_d = mag_a_q;
    mag_m_d = mag_m_q;
    acc_d   = acc_q;
    sign_d  = sign_q;
    pint_d  = pint_q;
    pfrac_d = pfrac_q;
    dec     = sm_decode(sm_word_t'(mul_if.quotient), sm_word_t'(mul_if.fractional), QW, FW);
    enc     = '0;

    case (state_q)
      IDLE: begin
        if (mul_if.start) begin
          state_d = CALC;
          cnt_d   = '0;
          mag_a_d = dec.mag[AW-1:0];
          // Unsigned view of -2^(MW-1) is exactly 2^(MW-1), so no overflow case exists.
          mag_m_d = mul_if.multiplier[MW-1] ? -mul_if.multiplier : mul_if.multiplier;
          sign_d  = dec.sign ^ mul_if.multiplier[MW-1];
          acc_d   = '0;
        end
      end
      CALC: begin
        acc_d   = (acc_q << 1) + (mag_m_q[MW-1] ? ACCW'(mag_a_q) : '0);
        mag_m_d = mag_m_q << 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          enc     = sm_encode(sign_q, sm_word_t'(acc_d), PW, FW);
          pint_d  = enc.int_v[PW-1:0];
          pfrac_d = enc.frac[FW-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_a_q <= '0;
      mag_m_q <= '0;
      acc_q   <= '0;
      sign_q  <= 1'b0;
      pint_q  <= '0;
      pfrac_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_a_q <= mag_a_d;
      mag_m_q <= mag_m_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
      pint_q  <= pint_d;
      pfrac_q <= pfrac_d;
    end
  end

  assign mul_if.busy         = (state_q != IDLE);
  assign mul_if.done         = (state_q == DONE);
  assign mul_if.product_int  = pint_q;
  assign mul_if.product_frac = pfrac_q;
  assign mul_if.dbg_state    = state_q;

  assign unused_bits = ^{dec.mag[SM_MAXW-1:AW], enc.int_v[SM_MAXW-1:PW], enc.frac[SM_MAXW-1:FW]};

endmodule

// File: tb/tb_fxp_multiplier_seq.sv
// Bench for fxp_multiplier_seq: directed vectors, handshake corner cases and divider round-trips.
module tb_fxp_multiplier_seq;
  import fxp_arith_pkg::*;

  localparam int QW = 32;
  localparam int FW = 16;
  localparam int MW = 32;
  localparam int PW = QW + MW;

  typedef struct {
    logic [PW-1:0] pi;
    logic [FW-1:0] pf;
    longint        issue;
    bit            rt;
    longint        dd;
    longint        dv;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic   clk  = 1'b0;
  logic   rstn = 1'b0;
  longint cyc  = 0;
  int     checks = 0;
  int     errors = 0;
  exp_t   exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fxp_multiplier_seq_if #(.QW(QW), .FW(FW), .MW(MW)) mif ();

  fxp_multiplier_seq #(
    .QUOTIENT_WIDTH(QW), .FRACTIONAL_WIDTH(FW), .MULT_WIDTH(MW)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .mul_if (mif)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- models ----------------
  function automatic void mul_model(input logic [QW-1:0] q, input logic [FW-1:0] f,
                                    input logic [MW-1:0] m,
                                    output logic [PW-1:0] pi, output logic [FW-1:0] pf);
    logic [QW-2:0]        ia;
    logic [PW-2:0]        top;
    logic signed [127:0]  a, ms, p, mag;
    ia  = q[QW-1] ? -q[QW-2:0] : q[QW-2:0];
    a   = '0;
    a[QW-2+FW:0] = {ia, f};
    if (q[QW-1]) a = -a;
    ms  = {{(128-MW){m[MW-1]}}, m};
    p   = a * ms;
    mag = (p < 0) ? -p : p;
    pf  = mag[FW-1:0];
    top = mag[PW-2+FW:FW];
    pi  = (p < 0) ? {1'b1, -top} : {1'b0, top};
  endfunction

  function automatic void div_model(input longint dd, input longint dv,
                                    output logic [QW-1:0] q, output logic [FW-1:0] f);
    longint        ad, av, qm, r;
    logic          s;
    logic [QW-2:0] ql;
    ad = (dd < 0) ? -dd : dd;
    av = (dv < 0) ? -dv : dv;
    qm = ad / av;
    r  = ad % av;
    f  = FW'((r << FW) / av);
    s  = (dd < 0) ^ (dv < 0);
    ql = (QW-1)'(qm);
    if (s) ql = -ql;
    q  = {s, ql};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    for (int i = 0; i < 100 && mif.busy; i++) @(negedge clk);
    if (mif.busy) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: busy=%0b still high after 100 cycles, expected 0", mif.busy);
    end
  endtask

  task automatic issue(input logic [QW-1:0] q, input logic [FW-1:0] f, input logic [MW-1:0] m,
                       input logic [PW-1:0] xpi, input logic [FW-1:0] xpf, input bit push,
                       input bit rt, input longint dd, input longint dv, output longint c);
    exp_t e;
    wait_idle();
    mif.start      = 1'b1;
    mif.quotient   = q;
    mif.fractional = f;
    mif.multiplier = m;
    c = cyc;
    if (push) begin
      e.pi = xpi; e.pf = xpf; e.issue = c; e.rt = rt; e.dd = dd; e.dv = dv;
      exp_q.push_back(e);
    end
    @(negedge clk);
    mif.start      = 1'b0;
    mif.quotient   = $urandom;
    mif.fractional = FW'($urandom);
    mif.multiplier = $urandom;
    chk("busy_after_accept", mif.busy, 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  exp_t                mon_e;
  logic [PW-2:0]       mon_low;
  logic signed [127:0] mon_v, mon_d, mon_av;

  always @(negedge clk) begin
    if (rstn && mif.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with no pending request, expected 0", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("product_int", mif.product_int, mon_e.pi);
        chk("product_frac", mif.product_frac, mon_e.pf);
        chk("done_latency", 128'(cyc - mon_e.issue), 128'(MW + 1));
        chk("busy_with_done", mif.busy, 1);
        if (mon_e.rt) begin
          mon_low = mif.product_int[PW-2:0];
          if (mif.product_int[PW-1]) mon_low = -mon_low;
          mon_v = '0;
          mon_v[PW-2+FW:0] = {mon_low, mif.product_frac};
          if (mif.product_int[PW-1]) mon_v = -mon_v;
          mon_d  = mon_e.dd;
          mon_d  = (mon_d <<< FW) - mon_v;
          if (mon_d < 0) mon_d = -mon_d;
          mon_av = mon_e.dv;
          if (mon_av < 0) mon_av = -mon_av;
          chk("roundtrip_within_lsb", (mon_d < mon_av) ? 128'd1 : 128'd0, 128'd1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [QW-1:0] q;
    logic [FW-1:0] f;
    logic [MW-1:0] m;
    logic [PW-1:0] pi;
    logic [FW-1:0] pf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    longint        c, c0;
    logic [QW-1:0] rq;
    logic [FW-1:0] rf;
    logic [PW-1:0] rpi;
    logic [FW-1:0] rpf;
    longint        dd, dv;
    exp_t          e;
    int            offs[3];

    vecs[0] = '{32'h0000_0003, 16'h8000, 32'h0000_0004, 64'h0000_0000_0000_000E, 16'h0000};
    vecs[1] = '{32'hFFFF_FFFD, 16'h4000, 32'hFFFF_FFFC, 64'h0000_0000_0000_000D, 16'h0000};
    vecs[2] = '{32'h8000_0000, 16'h8000, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFF, 16'h8000};
    vecs[3] = '{32'h0000_0001, 16'h0000, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 16'h0000};
    vecs[4] = '{32'h0000_0000, 16'h0000, 32'hFFFF_FFF9, 64'h0000_0000_0000_0000, 16'h0000};
    vecs[5] = '{32'h0000_0001, 16'h0001, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0001};
    vecs[6] = '{32'hFFFF_FFFF, 16'h0000, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFFB, 16'h0000};
    vecs[7] = '{32'h7FFF_FFFF, 16'h0000, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 16'h0000};
    vecs[8] = '{32'h8000_0000, 16'h0000, 32'h0000_0009, 64'h0000_0000_0000_0000, 16'h0000};
    vecs[9] = '{32'h0000_0000, 16'hFFFF, 32'h8000_0001, 64'hFFFF_FFFF_8000_8001, 16'h0001};

    mif.start = 1'b0; mif.quotient = '0; mif.fractional = '0; mif.multiplier = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", mif.busy, 0);
    chk("reset_done", mif.done, 0);
    chk("reset_product_int", mif.product_int, 0);
    chk("reset_product_frac", mif.product_frac, 0);
    chk("reset_state", mif.dbg_state, IDLE);
    rstn = 1'b1;
    @(negedge clk);

    // directed vectors
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].q, vecs[i].f, vecs[i].m, vecs[i].pi, vecs[i].pf, 1'b1, 1'b0, 0, 0, c);
      if (i == 1) begin
        repeat (5) @(negedge clk);
        chk("hold_during_calc_int", mif.product_int, vecs[0].pi);
        chk("hold_during_calc_frac", mif.product_frac, vecs[0].pf);
      end
    end

    // start held high: accepted every MW+2 cycles
    wait_idle();
    mif.start = 1'b1;
    mif.quotient = vecs[2].q; mif.fractional = vecs[2].f; mif.multiplier = vecs[2].m;
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      e.pi = vecs[2].pi; e.pf = vecs[2].pf; e.issue = c0 + k * (MW + 2);
      e.rt = 1'b0; e.dd = 0; e.dv = 0;
      exp_q.push_back(e);
    end
    while (cyc < c0 + 2 * (MW + 2) + 1) @(negedge clk);
    mif.start = 1'b0;

    // extra start pulses while busy, the last one landing in the done cycle
    issue(vecs[1].q, vecs[1].f, vecs[1].m, vecs[1].pi, vecs[1].pf, 1'b1, 1'b0, 0, 0, c);
    offs = '{3, 20, MW + 1};
    for (int k = 0; k < 3; k++) begin
      while (cyc < c + offs[k]) @(negedge clk);
      mif.start = 1'b1;
      mif.quotient = vecs[7].q; mif.fractional = vecs[7].f; mif.multiplier = vecs[7].m;
      @(negedge clk);
      mif.start = 1'b0;
    end

    // reset in the middle of a calculation discards it
    issue(vecs[3].q, vecs[3].f, vecs[3].m, '0, '0, 1'b0, 1'b0, 0, 0, c);
    while (cyc < c + 10) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("midreset_busy", mif.busy, 0);
    chk("midreset_done", mif.done, 0);
    chk("midreset_product_int", mif.product_int, 0);
    chk("midreset_product_frac", mif.product_frac, 0);
    chk("midreset_state", mif.dbg_state, IDLE);
    rstn = 1'b1;
    @(negedge clk);
    issue(vecs[9].q, vecs[9].f, vecs[9].m, vecs[9].pi, vecs[9].pf, 1'b1, 1'b0, 0, 0, c);

    // round-trips through a divider model
    for (int i = 0; i < 150; i++) begin
      dd = longint'($signed($urandom));
      if (dd == -64'sd2147483648) dd = 0;
      if (i % 2 == 0) begin
        dv = longint'($urandom_range(1, 1000));
        if ($urandom_range(0, 1) == 1) dv = -dv;
      end else begin
        dv = longint'($signed($urandom));
        if (dv == 0) dv = 1;
      end
      div_model(dd, dv, rq, rf);
      mul_model(rq, rf, MW'(dv), rpi, rpf);
      issue(rq, rf, MW'(dv), rpi, rpf, 1'b1, 1'b1, dd, dv, c);
    end

    // drain
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
